// File: rtl/vliw_branch_pkg.sv
// Shared types and constants for the VLIW execute-stage branch redirect logic.
package vliw_branch_pkg;

    typedef enum logic [2:0] {
        BEQ, BNE, BLT, BGE, BLTU, BGEU, J, JR
    } br_op_t;

    typedef enum logic [1:0] {
        IDLE, REDIRECT, SHADOW
    } brr_state_t;

    localparam int BUNDLE_BYTES = 16;
    localparam int INST_BYTES   = 4;

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational condition and target evaluation for one branch lane.
module branch_cond_eval
    import vliw_branch_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  br_op_t            op,
    input  logic [XLEN-1:0]   slot_pc,
    input  logic [XLEN-1:0]   op_a,
    input  logic [XLEN-1:0]   op_b,
    input  logic [15:0]       imm,
    output logic              taken,
    output logic [XLEN-1:0]   target
);

    logic [XLEN-1:0] offset;
    logic [XLEN-1:0] rel_target;

    // Immediate is a signed word offset, so scale by four after sign extension.
    assign offset     = {{(XLEN-18){imm[15]}}, imm, 2'b00};
    assign rel_target = slot_pc + XLEN'(INST_BYTES) + offset;

    always_comb begin
        taken  = 1'b0;
        target = rel_target;
        case (op)
            BEQ:  taken = (op_a == op_b);
            BNE:  taken = (op_a != op_b);
            BLT:  taken = ($signed(op_a) <  $signed(op_b));
            BGE:  taken = ($signed(op_a) >= $signed(op_b));
            BLTU: taken = (op_a <  op_b);
            BGEU: taken = (op_a >= op_b);
            J:    taken = 1'b1;
            JR: begin
                taken  = 1'b1;
                target = {op_a[XLEN-1:2], 2'b00};
            end
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_redirect_unit.sv
// Oldest-taken-branch select, redirect pulse and squash window for one VLIW bundle.
// Optional BRANCH_STATS_EN adds saturating resolved/taken counters.
module branch_redirect_unit
    import vliw_branch_pkg::*;
#(
    parameter int NUM_LANES     = 4,
    parameter int XLEN          = 32,
    parameter int SQUASH_CYCLES = 2
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            stall,
    input  logic [XLEN-1:0]                 bundle_pc,
    input  logic [NUM_LANES-1:0]            br_valid,
    input  br_op_t [NUM_LANES-1:0]          br_op,
    input  logic [NUM_LANES-1:0][XLEN-1:0]  br_op_a,
    input  logic [NUM_LANES-1:0][XLEN-1:0]  br_op_b,
    input  logic [NUM_LANES-1:0][15:0]      br_imm,
    output logic                            branch_taken,
    output logic [XLEN-1:0]                 new_pc,
    output logic                            br_misalign,
`ifdef BRANCH_STATS_EN
    output logic [31:0]                     stat_resolved,
    output logic [31:0]                     stat_taken,
`endif
    output brr_state_t                      fsm_state
);

    localparam int CW = (SQUASH_CYCLES > 1) ? $clog2(SQUASH_CYCLES) : 1;
    localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(BUNDLE_BYTES - 1);

    logic [NUM_LANES-1:0] lane_taken;
    logic [XLEN-1:0]      lane_target [NUM_LANES];
    logic                 win;
    logic [XLEN-1:0]      win_target;
    logic [CW-1:0]        count;

    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        branch_cond_eval #(.XLEN(XLEN)) u_eval (
            .op      (br_op[l]),
            .slot_pc (bundle_pc + XLEN'(l * INST_BYTES)),
            .op_a    (br_op_a[l]),
            .op_b    (br_op_b[l]),
            .imm     (br_imm[l]),
            .taken   (lane_taken[l]),
            .target  (lane_target[l])
        );
    end

    // Scan from the top lane down so the lowest qualifying lane is written last.
    always_comb begin
        win        = 1'b0;
        win_target = '0;
        for (int i = NUM_LANES - 1; i >= 0; i--) begin
            if (br_valid[i] && lane_taken[i]) begin
                win        = 1'b1;
                win_target = lane_target[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fsm_state    <= IDLE;
            branch_taken <= 1'b0;
            new_pc       <= '0;
            br_misalign  <= 1'b0;
            count        <= '0;
        end else begin
            case (fsm_state)
                IDLE: begin
                    if (!stall && win) begin
                        fsm_state    <= REDIRECT;
                        branch_taken <= 1'b1;
                        new_pc       <= win_target & ~ALIGN_MASK;
                        br_misalign  <= |(win_target & ALIGN_MASK);
                    end
                end
                REDIRECT: begin
                    // The PC gives redirects priority, so stall never stretches the pulse.
                    branch_taken <= 1'b0;
                    new_pc       <= '0;
                    br_misalign  <= 1'b0;
                    count        <= CW'(SQUASH_CYCLES - 1);
                    fsm_state    <= (SQUASH_CYCLES == 1) ? IDLE : SHADOW;
                end
                SHADOW: begin
                    if (!stall) begin
                        count <= count - CW'(1);
                        if (count <= CW'(1)) begin
                            fsm_state <= IDLE;
                        end
                    end
                end
                default: fsm_state <= IDLE;
            endcase
        end
    end

`ifdef BRANCH_STATS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_resolved <= '0;
            stat_taken    <= '0;
        end else if (fsm_state == IDLE && !stall) begin
            if (|br_valid && stat_resolved != 32'hFFFF_FFFF) begin
                stat_resolved <= stat_resolved + 32'd1;
            end
            if (win && stat_taken != 32'hFFFF_FFFF) begin
                stat_taken <= stat_taken + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_branch_redirect_unit.sv
// Directed bench for branch_redirect_unit: vector table plus multi-cycle sequences.
module tb_branch_redirect_unit;
    import vliw_branch_pkg::*;

    logic                  clk;
    logic                  rst;
    logic                  stall;
    logic [31:0]           bundle_pc;
    logic [3:0]            br_valid;
    br_op_t [3:0]          br_op;
    logic [3:0][31:0]      br_op_a;
    logic [3:0][31:0]      br_op_b;
    logic [3:0][15:0]      br_imm;
    logic                  branch_taken;
    logic [31:0]           new_pc;
    logic                  br_misalign;
    brr_state_t            fsm_state;
`ifdef BRANCH_STATS_EN
    logic [31:0]           stat_resolved;
    logic [31:0]           stat_taken;
`endif

    branch_redirect_unit dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .bundle_pc    (bundle_pc),
        .br_valid     (br_valid),
        .br_op        (br_op),
        .br_op_a      (br_op_a),
        .br_op_b      (br_op_b),
        .br_imm       (br_imm),
        .branch_taken (branch_taken),
        .new_pc       (new_pc),
        .br_misalign  (br_misalign),
`ifdef BRANCH_STATS_EN
        .stat_resolved(stat_resolved),
        .stat_taken   (stat_taken),
`endif
        .fsm_state    (fsm_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [3:0]  valid;
        br_op_t      op  [4];
        logic [31:0] a   [4];
        logic [31:0] b   [4];
        logic [15:0] imm [4];
        logic        exp_taken;
        logic [31:0] exp_pc;
        logic        exp_mis;
    } vec_t;

    localparam int NV = 12;
    vec_t vt [NV];

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_lane(input int vi, input int l, input br_op_t op,
                            input logic [31:0] a, input logic [31:0] b, input logic [15:0] imm);
        vt[vi].valid[l] = 1'b1;
        vt[vi].op[l]    = op;
        vt[vi].a[l]     = a;
        vt[vi].b[l]     = b;
        vt[vi].imm[l]   = imm;
    endtask

    task automatic set_exp(input int vi, input logic [31:0] pc, input logic tk,
                           input logic [31:0] epc, input logic mis);
        vt[vi].pc        = pc;
        vt[vi].exp_taken = tk;
        vt[vi].exp_pc    = epc;
        vt[vi].exp_mis   = mis;
    endtask

    task automatic drive(input vec_t v);
        bundle_pc = v.pc;
        br_valid  = v.valid;
        for (int l = 0; l < 4; l++) begin
            br_op[l]   = v.op[l];
            br_op_a[l] = v.a[l];
            br_op_b[l] = v.b[l];
            br_imm[l]  = v.imm[l];
        end
    endtask

    // Single-lane unconditional jump with zero offset: target = pc + 4.
    task automatic drive_jump(input logic [31:0] pc);
        bundle_pc = pc;
        br_valid  = 4'b0001;
        br_op[0]  = J;
        br_imm[0] = 16'h0000;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < NV; i++) begin
            vt[i].pc        = 32'h0;
            vt[i].valid     = 4'b0;
            vt[i].exp_taken = 1'b0;
            vt[i].exp_pc    = 32'h0;
            vt[i].exp_mis   = 1'b0;
            for (int l = 0; l < 4; l++) begin
                vt[i].op[l]  = BEQ;
                vt[i].a[l]   = 32'h0;
                vt[i].b[l]   = 32'h0;
                vt[i].imm[l] = 16'h0;
            end
        end
        // lane2 BEQ taken: 0x28+4+0x10 = 0x3C, aligned down to 0x30
        set_lane(0, 2, BEQ, 32'd5, 32'd5, 16'd4);
        set_exp (0, 32'h0040_0020, 1'b1, 32'h0040_0030, 1'b1);
        // lane1 BNE not taken, lane3 J wins: 0x2C+4 = 0x30
        set_lane(1, 1, BNE, 32'd7, 32'd7, 16'd9);
        set_lane(1, 3, J,   32'd0, 32'd0, 16'd0);
        set_exp (1, 32'h0040_0020, 1'b1, 32'h0040_0030, 1'b0);
        // signed BLT -1 < 1 taken: 0x20+4+0xC = 0x30
        set_lane(2, 0, BLT, 32'hFFFF_FFFF, 32'd1, 16'd3);
        set_exp (2, 32'h0040_0020, 1'b1, 32'h0040_0030, 1'b0);
        // unsigned BLTU same operands not taken
        set_lane(3, 0, BLTU, 32'hFFFF_FFFF, 32'd1, 16'd3);
        set_exp (3, 32'h0040_0020, 1'b0, 32'h0, 1'b0);
        // signed BGE 1 >= -1, backward by one word: 0x24+4-4 = 0x24
        set_lane(4, 1, BGE, 32'd1, 32'hFFFF_FFFF, 16'hFFFF);
        set_exp (4, 32'h0040_0020, 1'b1, 32'h0040_0020, 1'b1);
        // BGEU lane0 false, lane3 true: 0x2C+4+0x40 = 0x70
        set_lane(5, 0, BGEU, 32'd1, 32'hFFFF_FFFF, 16'd1);
        set_lane(5, 3, BGEU, 32'hFFFF_FFFF, 32'd1, 16'h0010);
        set_exp (5, 32'h0040_0020, 1'b1, 32'h0040_0070, 1'b0);
        // JR: 0x12345677 & ~3 = 0x12345674 -> 0x12345670
        set_lane(6, 1, JR, 32'h1234_5677, 32'd0, 16'd0);
        set_exp (6, 32'h0040_0020, 1'b1, 32'h1234_5670, 1'b1);
        // J present but br_valid clear: nothing happens
        set_lane(7, 0, J, 32'd0, 32'd0, 16'd0);
        vt[7].valid = 4'b0000;
        set_exp (7, 32'h0040_0020, 1'b0, 32'h0, 1'b0);
        // max positive offset: 0x28 + 0x1FFFC = 0x00420024
        set_lane(8, 0, BEQ, 32'd1, 32'd2, 16'd0);
        set_lane(8, 1, BNE, 32'd1, 32'd2, 16'h7FFF);
        set_exp (8, 32'h0040_0020, 1'b1, 32'h0042_0020, 1'b1);
        // address wrap: 0xFFFFFFFC + 4 = 0
        set_lane(9, 3, J, 32'd0, 32'd0, 16'd0);
        set_exp (9, 32'hFFFF_FFF0, 1'b1, 32'h0, 1'b0);
        // max negative offset: 0x24 - 0x20000 = 0x003E0024
        set_lane(10, 0, J, 32'd0, 32'd0, 16'h8000);
        set_exp (10, 32'h0040_0020, 1'b1, 32'h003E_0020, 1'b1);
        // every lane taken: lane0 wins with 0x24
        set_lane(11, 0, BEQ, 32'd3, 32'd3, 16'd0);
        set_lane(11, 1, J,   32'd0, 32'd0, 16'd5);
        set_lane(11, 2, JR,  32'h0000_1000, 32'd0, 16'd0);
        set_lane(11, 3, J,   32'd0, 32'd0, 16'd7);
        set_exp (11, 32'h0040_0020, 1'b1, 32'h0040_0020, 1'b1);

        rst   = 1'b0;
        stall = 1'b0;
        drive(vt[7]);
        br_valid = 4'b0000;
        #12;
        check("reset_taken", {31'b0, branch_taken}, 32'h0);
        check("reset_pc", new_pc, 32'h0);
        check("reset_mis", {31'b0, br_misalign}, 32'h0);
        check("reset_state", 32'(fsm_state), 32'(IDLE));
        rst = 1'b1;
        step();
        step();

        for (int i = 0; i < NV; i++) begin
            drive(vt[i]);
            step();
            check($sformatf("v%0d_taken", i), {31'b0, branch_taken}, {31'b0, vt[i].exp_taken});
            check($sformatf("v%0d_pc", i), new_pc, vt[i].exp_pc);
            check($sformatf("v%0d_mis", i), {31'b0, br_misalign}, {31'b0, vt[i].exp_mis});
            br_valid = 4'b0000;
            step();
            check($sformatf("v%0d_after", i), {31'b0, branch_taken}, 32'h0);
            step();
            step();
            check($sformatf("v%0d_idle", i), 32'(fsm_state), 32'(IDLE));
        end

        // Back-to-back taken branches: only the first and the post-window one redirect.
        drive_jump(32'h0040_0000);
        step();
        check("b2b_first_taken", {31'b0, branch_taken}, 32'h1);
        check("b2b_first_pc", new_pc, 32'h0040_0000);
        drive_jump(32'h0040_0100);
        step();
        check("b2b_drop1", {31'b0, branch_taken}, 32'h0);
        check("b2b_shadow", 32'(fsm_state), 32'(SHADOW));
        drive_jump(32'h0040_0200);
        step();
        check("b2b_drop2", {31'b0, branch_taken}, 32'h0);
        drive_jump(32'h0040_0300);
        step();
        check("b2b_second_taken", {31'b0, branch_taken}, 32'h1);
        check("b2b_second_pc", new_pc, 32'h0040_0300);
        br_valid = 4'b0000;
        step();
        check("b2b_end", {31'b0, branch_taken}, 32'h0);
        step();
        step();

        // Stall for three cycles in SHADOW stretches the window by three cycles.
        drive_jump(32'h0050_0000);
        step();
        check("shst_taken", {31'b0, branch_taken}, 32'h1);
        step();
        check("shst_enter", 32'(fsm_state), 32'(SHADOW));
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            check($sformatf("shst_hold%0d", k), 32'(fsm_state), 32'(SHADOW));
            check($sformatf("shst_quiet%0d", k), {31'b0, branch_taken}, 32'h0);
        end
        stall = 1'b0;
        step();
        check("shst_idle", 32'(fsm_state), 32'(IDLE));
        check("shst_idle_quiet", {31'b0, branch_taken}, 32'h0);
        step();
        check("shst_retake", {31'b0, branch_taken}, 32'h1);
        check("shst_retake_pc", new_pc, 32'h0050_0000);
        br_valid = 4'b0000;
        step();
        step();
        step();

        // Stall in IDLE with a winner: no capture until stall drops.
        stall = 1'b1;
        drive_jump(32'h0060_0010);
        for (int k = 0; k < 3; k++) begin
            step();
            check($sformatf("idst_hold%0d", k), {31'b0, branch_taken}, 32'h0);
            check($sformatf("idst_state%0d", k), 32'(fsm_state), 32'(IDLE));
        end
        stall = 1'b0;
        step();
        check("idst_taken", {31'b0, branch_taken}, 32'h1);
        check("idst_pc", new_pc, 32'h0060_0010);
        check("idst_mis", {31'b0, br_misalign}, 32'h1);
        br_valid = 4'b0000;
        step();
        step();
        step();

        // Asynchronous reset in the middle of a redirect pulse.
        drive_jump(32'h0070_0000);
        step();
        check("arst_pre_taken", {31'b0, branch_taken}, 32'h1);
        #1;
        rst = 1'b0;
        #1;
        check("arst_taken", {31'b0, branch_taken}, 32'h0);
        check("arst_pc", new_pc, 32'h0);
        check("arst_state", 32'(fsm_state), 32'(IDLE));
        br_valid = 4'b0000;
        @(negedge clk);
        rst = 1'b1;
`ifdef BRANCH_STATS_EN
        check("arst_stat_resolved", stat_resolved, 32'h0);
        check("arst_stat_taken", stat_taken, 32'h0);
`endif
        step();
        check("arst_post_quiet", {31'b0, branch_taken}, 32'h0);
        check("arst_post_state", 32'(fsm_state), 32'(IDLE));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
